mem_stage: RTL and testbench

- MIPS memory stage.
- Reads the EX/MEM latch outputs (control, ALU result, store data, branch target, zero, destination register) and resolves the branch decision.
- Performs the data-memory load/store with a parameterised wait-state controller, and registers results into the MEM/WB latch for writeback.
- Drives a stall back to the front of the pipeline while a multi-cycle access is pending.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/mem_stage_if.sv | 34 +++
 rtl/data_memory.sv | 24 ++
 rtl/mem_stage.sv | 111 +++++++++++
 tb/tb_mem_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control bit positions, widths, MEM-stage FSM states.
package mips_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned WB_W   = 2;
    localparam int unsigned M_W    = 3;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 4;

    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;
    localparam int unsigned M_BRANCH    = 2;
    localparam int unsigned M_MEMREAD   = 1;
    localparam int unsigned M_MEMWRITE  = 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        COMMIT
    } mem_state_t;

    // MEM/WB latch fields other than load data, which lives in the memory read port
    typedef struct packed {
        logic [WB_W-1:0]   wb_ctl;
        logic [WORD_W-1:0] alu_result;
        logic [REG_W-1:0]  write_reg;
    } memwb_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB + pipeline-control outputs of the memory stage.
interface mem_stage_if;
    import mips_pkg::*;

    logic [WB_W-1:0]   wb_ctlout;
    logic [M_W-1:0]    m_ctlout;
    logic [WORD_W-1:0] alu_result;
    logic [WORD_W-1:0] rdata2out;
    logic [WORD_W-1:0] add_result;
    logic              zero;
    logic [REG_W-1:0]  five_bit_muxout;

    logic              pcsrc;
    logic [WORD_W-1:0] branch_target;
    logic              stall;
    logic              misalign;
    logic [WB_W-1:0]   wb_ctl_q;
    logic [WORD_W-1:0] read_data_q;
    logic [WORD_W-1:0] alu_result_q;
    logic [REG_W-1:0]  write_reg_q;

    modport master (
        output wb_ctlout, m_ctlout, alu_result, rdata2out, add_result, zero, five_bit_muxout,
        input  pcsrc, branch_target, stall, misalign, wb_ctl_q, read_data_q, alu_result_q,
               write_reg_q
    );

    modport slave (
        input  wb_ctlout, m_ctlout, alu_result, rdata2out, add_result, zero, five_bit_muxout,
        output pcsrc, branch_target, stall, misalign, wb_ctl_q, read_data_q, alu_result_q,
               write_reg_q
    );

endinterface

// File: rtl/data_memory.sv
// Word-addressed data RAM: synchronous write, synchronous read returning the pre-write word.
module data_memory
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[addr];
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: branch resolve, wait-stated data-memory access, MEM/WB latch.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned MEM_LAT = 0
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall_q, misalign_q, misalign_d;
    logic              rd_valid_q;
    memwb_t            memwb_q;
    logic              do_access, capture, bubble;
    logic              rd, wr, access, misaligned;
    logic [ADDR_W-1:0] word_addr;
    logic [WORD_W-1:0] mem_rdata;

    assign rd         = bus.m_ctlout[M_MEMREAD];
    assign wr         = bus.m_ctlout[M_MEMWRITE];
    assign access     = rd | wr;
    assign misaligned = access && (bus.alu_result[1:0] != 2'b00);
    assign word_addr  = bus.alu_result[ADDR_W+1:2];

    data_memory #(.ADDR_W(ADDR_W)) u_dmem (
        .clk   (clk),
        .we    (do_access & wr),
        .re    (do_access & rd),
        .addr  (word_addr),
        .wdata (bus.rdata2out),
        .rdata (mem_rdata)
    );

    // Next state, wait counter and MEM/WB capture decisions
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        do_access  = 1'b0;
        capture    = 1'b0;
        bubble     = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (misaligned) begin
                    bubble     = 1'b1;
                    misalign_d = 1'b1;
                end else if (!access || MEM_LAT == 0) begin
                    capture   = 1'b1;
                    do_access = access;
                end else begin
                    bubble  = 1'b1;
                    cnt_d   = LAT_LOAD;
                    state_d = (LAT_LOAD == '0) ? COMMIT : WAIT;
                end
            end
            WAIT: begin
                bubble = 1'b1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = COMMIT;
            end
            COMMIT: begin
                capture   = 1'b1;
                do_access = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and MEM/WB registers; EX/MEM is held upstream while stall is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            stall_q    <= 1'b0;
            misalign_q <= 1'b0;
            rd_valid_q <= 1'b0;
            memwb_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stall_q    <= (state_d != IDLE);
            misalign_q <= misalign_d;
            if (capture) begin
                memwb_q.wb_ctl     <= bus.wb_ctlout;
                memwb_q.alu_result <= bus.alu_result;
                memwb_q.write_reg  <= bus.five_bit_muxout;
                if (do_access && rd) rd_valid_q <= 1'b1;
            end else if (bubble) begin
                memwb_q.wb_ctl <= '0;
            end
        end
    end

    assign bus.pcsrc         = bus.m_ctlout[M_BRANCH] & bus.zero;
    assign bus.branch_target = bus.add_result;
    assign bus.stall         = stall_q;
    assign bus.misalign      = misalign_q;
    assign bus.wb_ctl_q      = memwb_q.wb_ctl;
    assign bus.alu_result_q  = memwb_q.alu_result;
    assign bus.write_reg_q   = memwb_q.write_reg;
    // Load data lives in the RAM read register, which has no reset
    assign bus.read_data_q   = rd_valid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: three instances at MEM_LAT 0, 3 and 4.
module tb_mem_stage;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] tgt;
        logic        z;
        logic [4:0]  rd;
    } op_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        mis;
    } res_t;

    typedef struct packed {
        op_t  op;
        res_t exp;
        logic pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_checks = 0;
    int   n_err = 0;
    res_t sb[$];
    vec_t tab [13];

    always #5 clk = ~clk;

    mem_stage_if bus0 ();
    mem_stage_if bus3 ();
    mem_stage_if bus4 ();

    mem_stage #(.ADDR_W(8), .MEM_LAT(0)) u_lat0 (.clk(clk), .reset(rst_a), .bus(bus0));
    mem_stage #(.ADDR_W(8), .MEM_LAT(3)) u_lat3 (.clk(clk), .reset(rst_a), .bus(bus3));
    mem_stage #(.ADDR_W(8), .MEM_LAT(4)) u_lat4 (.clk(clk), .reset(rst_b), .bus(bus4));

    function automatic op_t mk_op(logic [1:0] wb, logic [2:0] m, logic [31:0] alu,
                                  logic [31:0] wdata, logic [31:0] tgt, logic z, logic [4:0] rd);
        return {wb, m, alu, wdata, tgt, z, rd};
    endfunction

    function automatic res_t mk_res(logic [1:0] wb, logic [31:0] rdata, logic [31:0] alu,
                                    logic [4:0] wreg, logic mis);
        return {wb, rdata, alu, wreg, mis};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int sel, input op_t o);
        case (sel)
            0: begin
                bus0.wb_ctlout = o.wb; bus0.m_ctlout = o.m; bus0.alu_result = o.alu;
                bus0.rdata2out = o.wdata; bus0.add_result = o.tgt; bus0.zero = o.z;
                bus0.five_bit_muxout = o.rd;
            end
            3: begin
                bus3.wb_ctlout = o.wb; bus3.m_ctlout = o.m; bus3.alu_result = o.alu;
                bus3.rdata2out = o.wdata; bus3.add_result = o.tgt; bus3.zero = o.z;
                bus3.five_bit_muxout = o.rd;
            end
            default: begin
                bus4.wb_ctlout = o.wb; bus4.m_ctlout = o.m; bus4.alu_result = o.alu;
                bus4.rdata2out = o.wdata; bus4.add_result = o.tgt; bus4.zero = o.z;
                bus4.five_bit_muxout = o.rd;
            end
        endcase
    endtask

    function automatic res_t sample(input int sel);
        case (sel)
            0:       return {bus0.wb_ctl_q, bus0.read_data_q, bus0.alu_result_q, bus0.write_reg_q, bus0.misalign};
            3:       return {bus3.wb_ctl_q, bus3.read_data_q, bus3.alu_result_q, bus3.write_reg_q, bus3.misalign};
            default: return {bus4.wb_ctl_q, bus4.read_data_q, bus4.alu_result_q, bus4.write_reg_q, bus4.misalign};
        endcase
    endfunction

    function automatic logic [33:0] ctl(input int sel);
        case (sel)
            0:       return {bus0.stall, bus0.pcsrc, bus0.branch_target};
            3:       return {bus3.stall, bus3.pcsrc, bus3.branch_target};
            default: return {bus4.stall, bus4.pcsrc, bus4.branch_target};
        endcase
    endfunction

    // Drive one op, wait (bounded) for the access to complete, then check against the scoreboard
    task automatic run_op(input int sel, input string nm, input op_t o, input res_t e,
                          input logic pc, input int exp_stall);
        int   nst = 0;
        int   bub = 0;
        logic done = 1'b0;
        res_t r, x;
        logic [33:0] c;
        drive(sel, o);
        sb.push_back(e);
        #1;
        c = ctl(sel);
        check({nm, "_pcsrc"}, 32'(c[32]), 32'(pc));
        check({nm, "_target"}, c[31:0], o.tgt);
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1;
            c = ctl(sel);
            if (c[33]) begin
                nst++;
                r = sample(sel);
                if (r.wb != 2'b00) bub++;
            end else begin
                done = 1'b1;
            end
        end
        check({nm, "_done"}, 32'(done), 32'd1);
        check({nm, "_stall_cycles"}, 32'(nst), 32'(exp_stall));
        check({nm, "_stall_bubble"}, 32'(bub), 32'd0);
        r = sample(sel);
        x = sb.pop_front();
        check({nm, "_wb_ctl"}, 32'(r.wb), 32'(x.wb));
        check({nm, "_rdata"}, r.rdata, x.rdata);
        check({nm, "_alu"}, r.alu, x.alu);
        check({nm, "_wreg"}, 32'(r.wreg), 32'(x.wreg));
        check({nm, "_misalign"}, 32'(r.mis), 32'(x.mis));
    endtask

    task automatic check_zero(input int sel, input string nm);
        res_t r = sample(sel);
        logic [33:0] c = ctl(sel);
        check({nm, "_wb_ctl"}, 32'(r.wb), 32'd0);
        check({nm, "_rdata"}, r.rdata, 32'd0);
        check({nm, "_alu"}, r.alu, 32'd0);
        check({nm, "_wreg"}, 32'(r.wreg), 32'd0);
        check({nm, "_misalign"}, 32'(r.mis), 32'd0);
        check({nm, "_stall"}, 32'(c[33]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        op_t nop = mk_op(2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);

        // wb, m, alu, wdata, tgt, z, rd  ->  wb_q, rdata_q, alu_q, wreg_q, misalign ; pcsrc
        tab[0]  = {mk_op(2'b00, 3'b001, 32'h10,   32'hDEADBEEF, 32'h0,  1'b0, 5'd0),
                   mk_res(2'b00, 32'h0,        32'h10,   5'd0, 1'b0), 1'b0};
        tab[1]  = {mk_op(2'b11, 3'b010, 32'h10,   32'h0,        32'h0,  1'b0, 5'd9),
                   mk_res(2'b11, 32'hDEADBEEF, 32'h10,   5'd9, 1'b0), 1'b0};
        tab[2]  = {mk_op(2'b00, 3'b100, 32'h5,    32'h0,        32'h40, 1'b1, 5'd0),
                   mk_res(2'b00, 32'hDEADBEEF, 32'h5,    5'd0, 1'b0), 1'b1};
        tab[3]  = {mk_op(2'b00, 3'b100, 32'h6,    32'h0,        32'h40, 1'b0, 5'd0),
                   mk_res(2'b00, 32'hDEADBEEF, 32'h6,    5'd0, 1'b0), 1'b0};
        tab[4]  = {mk_op(2'b10, 3'b000, 32'h1234, 32'h0,        32'h44, 1'b1, 5'd3),
                   mk_res(2'b10, 32'hDEADBEEF, 32'h1234, 5'd3, 1'b0), 1'b0};
        tab[5]  = {mk_op(2'b00, 3'b001, 32'h400,  32'h1,        32'h0,  1'b0, 5'd0),
                   mk_res(2'b00, 32'hDEADBEEF, 32'h400,  5'd0, 1'b0), 1'b0};
        tab[6]  = {mk_op(2'b11, 3'b010, 32'h0,    32'h0,        32'h0,  1'b0, 5'd4),
                   mk_res(2'b11, 32'h1,        32'h0,    5'd4, 1'b0), 1'b0};
        tab[7]  = {mk_op(2'b10, 3'b001, 32'h13,   32'hFFFFFFFF, 32'h0,  1'b0, 5'd2),
                   mk_res(2'b00, 32'h1,        32'h0,    5'd4, 1'b1), 1'b0};
        tab[8]  = {mk_op(2'b11, 3'b010, 32'h10,   32'h0,        32'h0,  1'b0, 5'd7),
                   mk_res(2'b11, 32'hDEADBEEF, 32'h10,   5'd7, 1'b0), 1'b0};
        tab[9]  = {mk_op(2'b11, 3'b011, 32'h10,   32'hCAFEF00D, 32'h0,  1'b0, 5'd8),
                   mk_res(2'b11, 32'hDEADBEEF, 32'h10,   5'd8, 1'b0), 1'b0};
        tab[10] = {mk_op(2'b11, 3'b010, 32'h10,   32'h0,        32'h0,  1'b0, 5'd8),
                   mk_res(2'b11, 32'hCAFEF00D, 32'h10,   5'd8, 1'b0), 1'b0};
        tab[11] = {mk_op(2'b11, 3'b010, 32'h12,   32'h0,        32'h0,  1'b0, 5'd1),
                   mk_res(2'b00, 32'hCAFEF00D, 32'h10,   5'd8, 1'b1), 1'b0};
        tab[12] = {nop, mk_res(2'b00, 32'hCAFEF00D, 32'h0, 5'd0, 1'b0), 1'b0};

        rst_a = 1'b0;
        rst_b = 1'b0;
        drive(0, nop);
        drive(3, nop);
        drive(4, nop);
        #12;
        check_zero(0, "rst_lat0");
        check_zero(3, "rst_lat3");
        check_zero(4, "rst_lat4");
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Single-cycle memory: store/load, branches, wrap-around, misalign, read-before-write
        for (int i = 0; i < 13; i++)
            run_op(0, $sformatf("lat0_v%0d", i), tab[i].op, tab[i].exp, tab[i].pc, 0);

        // Three wait states: stores and back-to-back loads each stall 3 cycles
        run_op(3, "lat3_st", mk_op(2'b00, 3'b001, 32'h20, 32'h12345678, 32'h0, 1'b0, 5'd0),
               mk_res(2'b00, 32'h0, 32'h20, 5'd0, 1'b0), 1'b0, 3);
        run_op(3, "lat3_ld", mk_op(2'b11, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, 5'd5),
               mk_res(2'b11, 32'h12345678, 32'h20, 5'd5, 1'b0), 1'b0, 3);
        run_op(3, "lat3_ld2", mk_op(2'b11, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, 5'd6),
               mk_res(2'b11, 32'h12345678, 32'h20, 5'd6, 1'b0), 1'b0, 3);
        run_op(3, "lat3_alu", mk_op(2'b10, 3'b000, 32'h77, 32'h0, 32'h0, 1'b0, 5'd2),
               mk_res(2'b10, 32'h12345678, 32'h77, 5'd2, 1'b0), 1'b0, 0);
        run_op(3, "lat3_mis", mk_op(2'b11, 3'b010, 32'h21, 32'h0, 32'h0, 1'b0, 5'd9),
               mk_res(2'b00, 32'h12345678, 32'h77, 5'd2, 1'b1), 1'b0, 0);

        // Four wait states: reset in the 2nd stall cycle aborts the pending store
        run_op(4, "lat4_st", mk_op(2'b00, 3'b001, 32'h8, 32'h11112222, 32'h0, 1'b0, 5'd0),
               mk_res(2'b00, 32'h0, 32'h8, 5'd0, 1'b0), 1'b0, 4);
        drive(4, mk_op(2'b00, 3'b001, 32'h8, 32'hAAAA5555, 32'h0, 1'b0, 5'd0));
        @(posedge clk);
        #1;
        check("abort_stall_c1", 32'(ctl(4) >> 33), 32'd1);
        @(posedge clk);
        #1;
        check("abort_stall_c2", 32'(ctl(4) >> 33), 32'd1);
        rst_b = 1'b0;
        #1;
        check_zero(4, "abort_rst");
        drive(4, nop);
        #2;
        rst_b = 1'b1;
        run_op(4, "lat4_ld", mk_op(2'b11, 3'b010, 32'h8, 32'h0, 32'h0, 1'b0, 5'd1),
               mk_res(2'b11, 32'h11112222, 32'h8, 5'd1, 1'b0), 1'b0, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
